// File: rtl/sram_client_mux.sv
// sram_client_mux: round-robin mux of NCLI toggle req/ack clients onto one SRAM arbiter port (SRAM_MUX_FIXED_PRIO_EN selects fixed priority)
module sram_client_mux #(
    parameter int NCLI       = 3,
    parameter int RD_LATENCY = 4
) (
    input  logic                 clk200,
    input  logic                 reset,
    input  logic [NCLI-1:0]      cli_req,
    output logic [NCLI-1:0]      cli_ack,
    input  logic [NCLI-1:0]      cli_read,
    input  logic [NCLI*19-1:0]   cli_address,
    input  logic [NCLI-1:0]      cli_lb,
    input  logic [NCLI-1:0]      cli_ub,
    input  logic [NCLI*16-1:0]   cli_wdata,
    output logic [15:0]          cli_rdata,
    output logic                 down_req,
    input  logic                 down_ack,
    output logic                 down_read,
    output logic [18:0]          down_address,
    output logic                 down_lb,
    output logic                 down_ub,
    output logic [15:0]          down_wdata,
    input  logic [15:0]          down_rdata
);
    localparam int GW = $clog2(NCLI);
    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_DATA = 2'd2, DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [GW-1:0]   rr_q, rr_d, g_q, g_d, gnt;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_q, req_d, rd_q, rd_d, lb_q, lb_d, ub_q, ub_d, any;
    logic [18:0]     addr_q, addr_d;
    logic [15:0]     wd_q, wd_d, rdata_q, rdata_d;
    logic [NCLI-1:0] ack_q, ack_d, pend;

    assign pend = cli_req ^ ack_q;

    // pick the first pending client scanning upward from rr_q, wrapping at NCLI
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int k = NCLI - 1; k >= 0; k--) begin
            if (pend[(int'(rr_q) + k) % NCLI]) begin
                any = 1'b1;
                gnt = GW'((int'(rr_q) + k) % NCLI);
            end
        end
    end

    // access sequencing: grant and issue, wait for accept, wait out read latency, complete
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        lb_d    = lb_q;
        ub_d    = ub_q;
        wd_d    = wd_q;
        ack_d   = ack_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (any) begin
                g_d     = gnt;
                rd_d    = cli_read[gnt];
                addr_d  = cli_address[19*gnt +: 19];
                lb_d    = cli_lb[gnt];
                ub_d    = cli_ub[gnt];
                wd_d    = cli_wdata[16*gnt +: 16];
                req_d   = ~req_q;
                state_d = ISSUE;
            end
            ISSUE: if (down_ack == req_q) begin
                cnt_d   = CW'(RD_LATENCY - 1);
                state_d = rd_q ? WAIT_DATA : DONE;
            end
            WAIT_DATA: if (cnt_q == '0) begin
                rdata_d = down_rdata;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            DONE: begin
                ack_d[g_q] = ~ack_q[g_q];
`ifdef SRAM_MUX_FIXED_PRIO_EN
                rr_d       = '0;
`else
                rr_d       = (g_q == GW'(NCLI - 1)) ? '0 : g_q + 1'b1;
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset aligns down_req with down_ack so nothing looks outstanding
    always_ff @(posedge clk200) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            req_q   <= down_ack;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            lb_q    <= 1'b0;
            ub_q    <= 1'b0;
            wd_q    <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            lb_q    <= lb_d;
            ub_q    <= ub_d;
            wd_q    <= wd_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign cli_ack      = ack_q;
    assign cli_rdata    = rdata_q;
    assign down_req     = req_q;
    assign down_read    = rd_q;
    assign down_address = addr_q;
    assign down_lb      = lb_q;
    assign down_ub      = ub_q;
    assign down_wdata   = wd_q;
endmodule

// File: tb/tb_sram_client_mux.sv
// tb_sram_client_mux: scoreboard bench for sram_client_mux with a toggle-protocol arbiter model
module tb_sram_client_mux;
    localparam int NCLI = 3;
    localparam int RDL  = 4;

    typedef struct {
        int          cli;
        logic        rd;
        logic [18:0] a;
        logic        lb;
        logic        ub;
        logic [15:0] wd;
    } txn_t;

    logic                clk200, reset;
    logic [NCLI-1:0]     cli_req, cli_ack, cli_read, cli_lb, cli_ub;
    logic [NCLI*19-1:0]  cli_address;
    logic [NCLI*16-1:0]  cli_wdata;
    logic [15:0]         cli_rdata;
    logic                down_req, down_ack, down_read, down_lb, down_ub;
    logic [18:0]         down_address;
    logic [15:0]         down_wdata, down_rdata;

    logic        c_rd [NCLI];
    logic [18:0] c_a  [NCLI];
    logic        c_lb [NCLI];
    logic        c_ub [NCLI];
    logic [15:0] c_wd [NCLI];

    int          n_chk = 0, n_pass = 0;
    txn_t        exp_q[$];
    txn_t        cur;
    logic        busy;
    int          cur_g, rr_m, g, fi;
    logic [NCLI-1:0] m_ack, pend_edge, prev_ack;
    logic        prev_req;
    logic [15:0] m_rdata, rd_next, rd_ret;

    sram_client_mux #(.NCLI(NCLI), .RD_LATENCY(RDL)) dut (
        .clk200(clk200), .reset(reset),
        .cli_req(cli_req), .cli_ack(cli_ack), .cli_read(cli_read),
        .cli_address(cli_address), .cli_lb(cli_lb), .cli_ub(cli_ub),
        .cli_wdata(cli_wdata), .cli_rdata(cli_rdata),
        .down_req(down_req), .down_ack(down_ack), .down_read(down_read),
        .down_address(down_address), .down_lb(down_lb), .down_ub(down_ub),
        .down_wdata(down_wdata), .down_rdata(down_rdata)
    );

    initial clk200 = 1'b0;
    always #5 clk200 = ~clk200;

    always_comb begin
        cli_read    = '0;
        cli_lb      = '0;
        cli_ub      = '0;
        cli_address = '0;
        cli_wdata   = '0;
        for (int i = 0; i < NCLI; i++) begin
            cli_read[i]           = c_rd[i];
            cli_lb[i]             = c_lb[i];
            cli_ub[i]             = c_ub[i];
            cli_address[19*i +: 19] = c_a[i];
            cli_wdata[16*i +: 16]   = c_wd[i];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, want);
    endtask

    function automatic int pick(input logic [NCLI-1:0] p, input int r);
        for (int k = 0; k < NCLI; k++)
            if (p[(r + k) % NCLI]) return (r + k) % NCLI;
        return -1;
    endfunction

    task automatic issue(input int i, input logic rd, input logic [18:0] a,
                         input logic lb, input logic ub, input logic [15:0] wd);
        txn_t t;
        t.cli = i; t.rd = rd; t.a = a; t.lb = lb; t.ub = ub; t.wd = wd;
        c_rd[i] = rd; c_a[i] = a; c_lb[i] = lb; c_ub[i] = ub; c_wd[i] = wd;
        exp_q.push_back(t);
        cli_req[i] = ~cli_req[i];
    endtask

    task automatic wait_done(input int i);
        bit ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk200);
            ok = (cli_ack[i] == cli_req[i]);
        end
        chk($sformatf("done_c%0d", i), 64'(ok), 64'(1));
    endtask

    task automatic client(input int i, input int n);
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk200);
            #1;
            issue(i, 1'($urandom_range(0, 1)), 19'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom));
            wait_done(i);
        end
    endtask

    // pending set as the DUT sees it at each active edge
    always @(posedge clk200) pend_edge <= cli_req ^ m_ack;

    // arbiter model: random accept delay, read data valid RDL cycles after the ack toggle
    initial begin
        down_ack   = 1'b0;
        down_rdata = '0;
        rd_next    = 16'h1234;
        rd_ret     = '0;
        forever begin
            @(negedge clk200);
            if (!reset && down_req !== down_ack) begin
                repeat ($urandom_range(0, 3)) @(negedge clk200);
                if (!reset && down_req !== down_ack) begin
                    #1;
                    rd_ret     = rd_next;
                    down_rdata = ~rd_next;
                    down_ack   = down_req;
                    rd_next    = 16'($urandom);
                    repeat (RDL) @(posedge clk200);
                    #1;
                    down_rdata = rd_ret;
                end
            end
        end
    end

    // monitor: checks every downstream issue and every client completion against the model
    always @(negedge clk200) begin
        if (reset) begin
            exp_q.delete();
            busy     = 1'b0;
            m_ack    = '0;
            rr_m     = 0;
            m_rdata  = '0;
            prev_req = down_req;
            prev_ack = cli_ack;
        end else begin
            if (down_req !== prev_req) begin
                chk("one_outstanding", 64'(busy), 64'(0));
                g  = pick(pend_edge, rr_m);
                fi = -1;
                for (int k = 0; k < exp_q.size(); k++)
                    if (exp_q[k].cli == g && fi < 0) fi = k;
                chk("grant_known", 64'(fi >= 0), 64'(1));
                if (fi >= 0) begin
                    cur = exp_q[fi];
                    exp_q.delete(fi);
                    chk($sformatf("issue_c%0d", g),
                        64'({down_read, down_address, down_lb, down_ub, down_wdata}),
                        64'({cur.rd, cur.a, cur.lb, cur.ub, cur.wd}));
                    busy  = 1'b1;
                    cur_g = g;
                end
            end else if (busy && down_req !== down_ack) begin
                chk("down_stable",
                    64'({down_read, down_address, down_lb, down_ub, down_wdata}),
                    64'({cur.rd, cur.a, cur.lb, cur.ub, cur.wd}));
            end
            if (cli_ack !== prev_ack) begin
                chk("ack_bit", 64'(busy ? (cli_ack ^ prev_ack) : '1), 64'(NCLI'(1) << cur_g));
                if (busy && cur.rd) m_rdata = rd_ret;
                chk("rdata", 64'(cli_rdata), 64'(m_rdata));
                if (busy) begin
                    m_ack[cur_g] = ~m_ack[cur_g];
`ifdef SRAM_MUX_FIXED_PRIO_EN
                    rr_m = 0;
`else
                    rr_m = (cur_g + 1) % NCLI;
`endif
                end
                busy = 1'b0;
            end
            prev_req = down_req;
            prev_ack = cli_ack;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic r0;
        int lat;
        reset   = 1'b1;
        cli_req = '0;
        for (int i = 0; i < NCLI; i++) begin
            c_rd[i] = 1'b0; c_a[i] = '0; c_lb[i] = 1'b0; c_ub[i] = 1'b0; c_wd[i] = '0;
        end
        repeat (3) @(posedge clk200);
        #1 reset = 1'b0;
        @(negedge clk200);
        chk("rst_cli_ack", 64'(cli_ack), 64'(0));
        chk("rst_rdata", 64'(cli_rdata), 64'(0));
        chk("rst_down_req", 64'(down_req), 64'(down_ack));
        chk("rst_down", 64'({down_read, down_address, down_lb, down_ub, down_wdata}), 64'(0));
        // read from c0 with a known return value
        #1 rd_next = 16'hA55A;
        issue(0, 1'b1, 19'h00010, 1'b1, 1'b1, 16'h0);
        wait_done(0);
        chk("t2_rdata", 64'(cli_rdata), 64'(16'hA55A));
        // single write from c1; only ack bit 1 moves
        #1 issue(1, 1'b0, 19'h12345, 1'b1, 1'b1, 16'hBEEF);
        wait_done(1);
        chk("t1_acks", 64'(cli_ack), 64'(3'b011));
        // c0 and c2 together right after a c1 grant
        @(negedge clk200);
        #1;
        fork
            begin issue(0, 1'b0, 19'h00AAA, 1'b1, 1'b0, 16'h1111); wait_done(0); end
            begin issue(2, 1'b0, 19'h00CCC, 1'b0, 1'b1, 16'h2222); wait_done(2); end
        join
        // byte write from c2, then an immediate re-request in the ack cycle
        @(negedge clk200);
        #1 issue(2, 1'b0, 19'h7FFFF, 1'b0, 1'b1, 16'h00FF);
        wait_done(2);
        r0 = down_req;
        issue(2, 1'b0, 19'h00001, 1'b0, 1'b1, 16'hFF00);
        lat = 0;
        for (int k = 1; k <= 3 && lat == 0; k++) begin
            @(negedge clk200);
            if (down_req !== r0) lat = k;
        end
        chk("b2b_latency", 64'(lat >= 1 && lat <= 2), 64'(1));
        chk("b2b_lb_ub", 64'({down_lb, down_ub}), 64'(2'b01));
        wait_done(2);
        // two bursts of simultaneous requests from all clients
        for (int b = 0; b < 2; b++) begin
            @(negedge clk200);
            #1;
            fork
                begin issue(0, 1'b1, 19'(16 * b + 1), 1'b1, 1'b1, 16'hA000); wait_done(0); end
                begin issue(1, 1'b0, 19'(16 * b + 2), 1'b1, 1'b1, 16'hB000); wait_done(1); end
                begin issue(2, 1'b1, 19'(16 * b + 3), 1'b1, 1'b1, 16'hC000); wait_done(2); end
            join
        end
        // random traffic from all clients
        fork
            client(0, 25);
            client(1, 25);
            client(2, 25);
        join
        repeat (10) @(negedge clk200);
        // reset during the read-latency wait
        #1 issue(0, 1'b1, 19'h00777, 1'b1, 1'b1, 16'h0);
        lat = 0;
        for (int k = 0; k < 50 && lat == 0; k++) begin
            @(negedge clk200);
            if (down_req !== down_ack) lat = 1;
        end
        for (int k = 0; k < 50 && lat == 1; k++) begin
            @(negedge clk200);
            if (down_req === down_ack) lat = 2;
        end
        chk("rst_accept_seen", 64'(lat), 64'(2));
        #1 reset = 1'b1;
        cli_req = '0;
        repeat (2) @(posedge clk200);
        #1 reset = 1'b0;
        @(negedge clk200);
        chk("mid_rst_req", 64'(down_req), 64'(down_ack));
        chk("mid_rst_ack", 64'(cli_ack), 64'(0));
        chk("mid_rst_rdata", 64'(cli_rdata), 64'(0));
        r0 = down_req;
        repeat (10) @(negedge clk200);
        chk("mid_rst_quiet", 64'(down_req), 64'(r0));
        chk("mid_rst_rdata_hold", 64'(cli_rdata), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
